sha2_msg_sched: RTL and testbench
=================================

// Module: sha2_msg_sched
// PURPOSE
//  Parametrised SHA-2 message scheduler. Accepts 16 block words W[0..15] over a valid/ready stream
//  and emits the full schedule W[0..ROUNDS-1], one word per beat. Backpressure is supported on both sides.
//  Uses a 16-word sliding window instead of a full ROUNDS-deep array.
//  Sits between the block loader and the compression round engine; serves SHA-224/256 (32-bit) and SHA-384/512 (64-bit).
// PARAMETERS
//  DATA_WIDTH  32  word width; only 32 or 64 legal (selects sigma rotations)
//  ROUNDS      64  schedule length; 64 for DATA_WIDTH=32, 80 for DATA_WIDTH=64
//  RND_W        7  width of out_round; must satisfy 2**RND_W >= ROUNDS
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  in_valid   in   1           in_data holds a block word
//  in_ready   out  1           scheduler accepts a word this cycle
//  in_data    in   DATA_WIDTH  block word, W[0] first, big-endian word order
//  out_valid  out  1           out_data/out_round/out_last valid
//  out_ready  in   1           consumer takes the output beat
//  out_data   out  DATA_WIDTH  schedule word W[t]
//  out_round  out  RND_W       index t of out_data
//  out_last   out  1           high with W[ROUNDS-1]
//  busy       out  1           high from the first accepted word until the last beat is taken
// BEHAVIOUR
//  Reset: state=LOAD, in_ready=0 for that cycle only, out_valid=0, out_data=0, out_round=0, out_last=0,
//    busy=0, window and counters=0.
//  Beat rules: in-beat = in_valid&in_ready; out-beat = out_valid&out_ready.
//    The output register advances only when it is free: adv = !out_valid | out_ready.
//  FSM LOAD:
//    in_ready = adv.
//    Each in-beat: shift in_data into win[15] (win[0] oldest); load out_data=in_data, out_round=cnt,
//      set out_valid, cnt++.
//    The 16th in-beat (cnt==15) goes to EXPAND. Words are forwarded with 1-cycle latency.
//  FSM EXPAND:
//    in_ready=0; in_valid is ignored.
//    Each cycle with adv: W = s1(win[14]) + win[9] + s0(win[1]) + win[0], mod 2**DATA_WIDTH
//      (carries discarded). Shift W into the window; out_data=W, out_round=cnt, cnt++.
//    When cnt==ROUNDS-1: also set out_last and go to DRAIN.
//    Sigmas for DATA_WIDTH=32:
//      s0 = ROTR7 ^ ROTR18 ^ SHR3
//      s1 = ROTR17 ^ ROTR19 ^ SHR10
//    Sigmas for DATA_WIDTH=64:
//      s0 = ROTR1 ^ ROTR8 ^ SHR7
//      s1 = ROTR19 ^ ROTR61 ^ SHR6
//  FSM DRAIN:
//    in_ready=0. On the out-beat of the last word: out_valid=0, out_last=0, cnt=0, busy=0, go to LOAD.
//    in_ready rises the cycle after that beat; there is no overlap between blocks.
//  Stall: with out_valid=1 and out_ready=0, out_data, out_round, out_last, window and cnt hold stable.
//  out_valid never drops without an out-beat.
//  Gaps: in_valid gaps in LOAD insert bubbles only; the schedule is unaffected.
//  Throughput: one word/cycle with out_ready tied high; a block takes ROUNDS+1 cycles to the last beat.
//  Reset mid-block: async clear to reset values; the partial block is discarded and the next in-beat is W[0].
// CONFIGURATION
//  SHA2_MSCHED_ABORT_EN defined:
//    adds input abort_in (1 bit, synchronous).
//    abort_in=1 at a clock edge forces state LOAD, cnt=0, out_valid=0, out_last=0, busy=0,
//      and clears the window.
//    abort_in has priority over a same-cycle in-beat or out-beat; the beat is dropped.
//  SHA2_MSCHED_ABORT_EN not defined: no abort_in port; flush only via rst_n.
// TESTING
//  T1 SHA-256 "abc": W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1
//     -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB with out_last=1; 64 beats, out_round 0..63.
//  T2 Random out_ready (50%) and in_valid gaps on T1 data -> identical 64-word sequence;
//     no drop or duplicate; outputs stable while stalled.
//  T3 DATA_WIDTH=64, ROUNDS=80, SHA-512 "abc" (W0=0x6162638000000000, W15=0x18)
//     -> 80 beats matching the reference model; W16=0x6162638000000000.
//  T4 Back-to-back blocks: second block's in_valid held high during the first block
//     -> in_ready=0 until the cycle after the out_last beat; both schedules correct.
//  T5 rst_n pulsed low at out_round=30 -> all outputs at reset values immediately;
//     a fresh T1 block then yields the T1 results.
//  T6 (ABORT_EN) abort_in at out_round=20 with out_valid=1
//     -> out_valid=0 next cycle, busy=0; the next in-beat is emitted as out_round=0.

Source files
------------

// File: rtl/sha2_msg_sched.sv
// sha2_msg_sched: SHA-2 message schedule generator for 32-bit (SHA-224/256)
// and 64-bit (SHA-384/512) words. Takes the 16 block words over a
// valid/ready stream and emits W[0..ROUNDS-1], one word per output beat,
// using a 16-word sliding window.
// Optional synchronous flush input abort_in exists only when the macro
// SHA2_MSCHED_ABORT_EN is defined; otherwise only rst_n flushes a block.
module sha2_msg_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int ROUNDS     = 64,
  parameter int RND_W      = 7
) (
`ifdef SHA2_MSCHED_ABORT_EN
  input  logic                  abort_in,
`endif
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [RND_W-1:0]      out_round,
  output logic                  out_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_win [16];
  logic [RND_W-1:0]      r_cnt;
  logic                  r_armed;
  logic                  r_outValid;
  logic [DATA_WIDTH-1:0] r_outData;
  logic [RND_W-1:0]      r_outRound;
  logic                  r_outLast;
  logic                  r_busy;

  logic                  w_abort;
  logic                  w_adv;
  logic                  w_inReady;
  logic                  w_inBeat;
  logic                  w_outBeat;
  logic                  w_shiftEn;
  logic [DATA_WIDTH-1:0] w_shiftIn;
  logic [DATA_WIDTH-1:0] w_newWord;
  logic                  w_loadDone;
  logic                  w_expandDone;

  // Rotate right by a constant amount within one word.
  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                 input int unsigned n);
    return (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  // Small sigma 0; rotation amounts depend on the word size.
  function automatic logic [DATA_WIDTH-1:0] sigma0(input logic [DATA_WIDTH-1:0] x);
    if (DATA_WIDTH == 64)
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  // Small sigma 1; rotation amounts depend on the word size.
  function automatic logic [DATA_WIDTH-1:0] sigma1(input logic [DATA_WIDTH-1:0] x);
    if (DATA_WIDTH == 64)
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef SHA2_MSCHED_ABORT_EN
  assign w_abort = abort_in;
`else
  assign w_abort = 1'b0;
`endif

  // Handshake decode: the output register may take a new word only when it
  // is empty or its current word is leaving this cycle.
  assign w_adv        = !r_outValid || out_ready;
  assign w_inReady    = (r_state == ST_LOAD) && r_armed && w_adv;
  assign w_inBeat     = in_valid && w_inReady;
  assign w_outBeat    = r_outValid && out_ready;
  assign w_loadDone   = (r_cnt == RND_W'(15));
  assign w_expandDone = (r_cnt == RND_W'(ROUNDS - 1));

  // Next expanded word from the oldest/younger window taps (mod 2**DATA_WIDTH).
  assign w_newWord = sigma1(r_win[14]) + r_win[9] + sigma0(r_win[1]) + r_win[0];

  // Window shifts on every accepted block word and on every expanded word.
  assign w_shiftEn = ((r_state == ST_LOAD) && w_inBeat) ||
                     ((r_state == ST_EXPAND) && w_adv);
  assign w_shiftIn = (r_state == ST_LOAD) ? in_data : w_newWord;

  // Sliding window: win[0] is the oldest word, win[15] the newest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (w_abort) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (w_shiftEn) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i + 1];
      r_win[15] <= w_shiftIn;
    end
  end

  // Control FSM plus registered output beat; input side is held off for the
  // first cycle after reset and whenever a block is expanding or draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_LOAD;
      r_cnt      <= '0;
      r_armed    <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outRound <= '0;
      r_outLast  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_abort) begin
        r_state    <= ST_LOAD;
        r_cnt      <= '0;
        r_outValid <= 1'b0;
        r_outLast  <= 1'b0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_inBeat) begin
              r_outData  <= in_data;
              r_outRound <= r_cnt;
              r_outValid <= 1'b1;
              r_outLast  <= 1'b0;
              r_busy     <= 1'b1;
              r_cnt      <= r_cnt + 1'b1;
              if (w_loadDone) r_state <= ST_EXPAND;
            end else if (w_outBeat) begin
              r_outValid <= 1'b0;
            end
          end
          ST_EXPAND: begin
            if (w_adv) begin
              r_outData  <= w_newWord;
              r_outRound <= r_cnt;
              r_outValid <= 1'b1;
              r_cnt      <= r_cnt + 1'b1;
              if (w_expandDone) begin
                r_outLast <= 1'b1;
                r_state   <= ST_DRAIN;
              end
            end
          end
          ST_DRAIN: begin
            if (w_outBeat) begin
              r_outValid <= 1'b0;
              r_outLast  <= 1'b0;
              r_cnt      <= '0;
              r_busy     <= 1'b0;
              r_state    <= ST_LOAD;
            end
          end
          default: begin
            r_state <= ST_LOAD;
          end
        endcase
      end
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_round = r_outRound;
  assign out_last  = r_outLast;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sha2_msg_sched.sv
// tb_sha2_msg_sched: self-checking bench for sha2_msg_sched. A 32-bit and a
// 64-bit instance are driven from one cycle loop; expected schedules come
// from a plain-arithmetic model of the SHA-2 schedule recurrence.
module tb_sha2_msg_sched;

  logic clk = 1'b0;
  logic rst_n;

  // Free-running clock shared by both instances.
  always #5 clk = ~clk;

`ifdef SHA2_MSCHED_ABORT_EN
  logic abortIn = 1'b0;
`endif

  logic        inValid32, inReady32, outValid32, outReady32, outLast32, busy32;
  logic [31:0] inData32, outData32;
  logic [6:0]  outRound32;
  logic        inValid64, inReady64, outValid64, outReady64, outLast64, busy64;
  logic [63:0] inData64, outData64;
  logic [6:0]  outRound64;

  sha2_msg_sched #(.DATA_WIDTH(32), .ROUNDS(64), .RND_W(7)) dut32 (
`ifdef SHA2_MSCHED_ABORT_EN
    .abort_in(abortIn),
`endif
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid32), .in_ready(inReady32), .in_data(inData32),
    .out_valid(outValid32), .out_ready(outReady32), .out_data(outData32),
    .out_round(outRound32), .out_last(outLast32), .busy(busy32)
  );

  sha2_msg_sched #(.DATA_WIDTH(64), .ROUNDS(80), .RND_W(7)) dut64 (
`ifdef SHA2_MSCHED_ABORT_EN
    .abort_in(abortIn),
`endif
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid64), .in_ready(inReady64), .in_data(inData64),
    .out_valid(outValid64), .out_ready(outReady64), .out_data(outData64),
    .out_round(outRound64), .out_last(outLast64), .busy(busy64)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] blk [16];
  logic [63:0] txWords [$];
  logic [63:0] expData [$];
  logic [63:0] rxData  [$];

  // Reference rotate for either word size.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input bit is64);
    logic [31:0] lo;
    if (is64) return (x >> n) | (x << (64 - n));
    lo = x[31:0];
    return {32'h0, (lo >> n) | (lo << (32 - n))};
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input bit is64);
    if (is64) return rotr(x, 1, 1'b1) ^ rotr(x, 8, 1'b1) ^ (x >> 7);
    return rotr(x, 7, 1'b0) ^ rotr(x, 18, 1'b0) ^ (x >> 3);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input bit is64);
    if (is64) return rotr(x, 19, 1'b1) ^ rotr(x, 61, 1'b1) ^ (x >> 6);
    return rotr(x, 17, 1'b0) ^ rotr(x, 19, 1'b0) ^ (x >> 10);
  endfunction

  // Queue the current blk for sending and append its full schedule to the
  // expected stream.
  task automatic addBlock(input bit is64);
    logic [63:0] w [80];
    logic [63:0] mask;
    int rounds;
    rounds = is64 ? 80 : 64;
    mask   = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    for (int t = 0; t < 16; t++) begin
      w[t] = blk[t] & mask;
      txWords.push_back(w[t]);
    end
    for (int t = 16; t < rounds; t++)
      w[t] = (sig1(w[t-2], is64) + w[t-7] + sig0(w[t-15], is64) + w[t-16]) & mask;
    for (int t = 0; t < rounds; t++) expData.push_back(w[t]);
  endtask

  // The "abc" single-block message for SHA-256 or SHA-512.
  task automatic setAbc(input bit is64);
    for (int i = 0; i < 16; i++) blk[i] = 64'h0;
    blk[0]  = is64 ? 64'h6162638000000000 : 64'h0000000061626380;
    blk[15] = 64'h18;
  endtask

  task automatic setRandom(input bit is64);
    for (int i = 0; i < 16; i++)
      blk[i] = is64 ? {$urandom, $urandom} : {32'h0, $urandom};
  endtask

  task automatic clearQueues();
    txWords.delete();
    expData.delete();
    rxData.delete();
  endtask

  // Cycle-driven stream: inputs change on the falling edge, outputs are
  // sampled 1 time unit later, and the beats seen there happen at the next
  // rising edge. Every valid output is checked against the expected word at
  // the head of the stream, which also proves stability while stalled.
  task automatic runStream(input bit is64, input int readyPct, input int gapPct,
                           input int beatLimit, input int maxCycles,
                           output int firstIn, output int lastOut);
    int R, idx, got, cyc, target, nWords;
    bit lastPrev, v, r, ir, ov, ol, bz;
    logic [63:0] d, od;
    logic [6:0] orr, expRound;
    R = is64 ? 80 : 64;
    idx = 0; got = 0; cyc = 0; lastPrev = 1'b0;
    firstIn = -1; lastOut = -1;
    nWords = txWords.size();
    target = (beatLimit > 0) ? beatLimit : expData.size();
    while (got < target && cyc < maxCycles) begin
      @(negedge clk);
      cyc++;
      r = ($urandom_range(99) < readyPct);
      v = (idx < nWords) && ($urandom_range(99) >= gapPct);
      d = v ? txWords[idx] : {$urandom, $urandom};
      if (is64) begin
        inValid64 = v; inData64 = d; outReady64 = r;
      end else begin
        inValid32 = v; inData32 = d[31:0]; outReady32 = r;
      end
      #1;
      ir  = is64 ? inReady64 : inReady32;
      ov  = is64 ? outValid64 : outValid32;
      od  = is64 ? outData64 : {32'h0, outData32};
      orr = is64 ? outRound64 : outRound32;
      ol  = is64 ? outLast64 : outLast32;
      bz  = is64 ? busy64 : busy32;
      if (idx < nWords) begin
        total++;
        if (ir && idx >= 16 * (got / R + 1)) begin
          bad++;
          $display("FAIL in_ready_overlap got=%0b want=0 (word %0d, beats %0d)", ir, idx, got);
        end
        if (lastPrev) begin
          total++;
          if (ir !== 1'b1) begin
            bad++;
            $display("FAIL in_ready_rise got=%0b want=1", ir);
          end
        end
      end
      lastPrev = 1'b0;
      if (v && ir) begin
        if (firstIn < 0) firstIn = cyc;
        idx++;
      end
      if (ov) begin
        expRound = 7'(got % R);
        total += 4;
        if (od !== expData[got]) begin
          bad++;
          $display("FAIL data[%0d] got=%h want=%h", got, od, expData[got]);
        end
        if (orr !== expRound) begin
          bad++;
          $display("FAIL round[%0d] got=%0d want=%0d", got, orr, expRound);
        end
        if (ol !== ((got % R) == R - 1)) begin
          bad++;
          $display("FAIL last[%0d] got=%0b want=%0b", got, ol, ((got % R) == R - 1));
        end
        if (bz !== 1'b1) begin
          bad++;
          $display("FAIL busy_during[%0d] got=%0b want=1", got, bz);
        end
        if (r) begin
          rxData.push_back(od);
          if ((got % R) == R - 1) begin
            lastPrev = 1'b1;
            lastOut  = cyc;
          end
          got++;
        end
      end
    end
    total++;
    if (got < target) begin
      bad++;
      $display("FAIL stream_timeout got=%0d beats want=%0d", got, target);
    end
    if (is64) inValid64 = 1'b0; else inValid32 = 1'b0;
  endtask

  // Outputs at reset values while rst_n is low; in_ready opens after reset.
  task automatic test_reset();
    inValid32 = 1'b0; inData32 = '0; outReady32 = 1'b1;
    inValid64 = 1'b0; inData64 = '0; outReady64 = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total += 7;
    if (outValid32 !== 1'b0) begin bad++; $display("FAIL rst_valid32 got=%0b want=0", outValid32); end
    if (outData32 !== 32'h0) begin bad++; $display("FAIL rst_data32 got=%h want=0", outData32); end
    if (outRound32 !== 7'd0) begin bad++; $display("FAIL rst_round32 got=%0d want=0", outRound32); end
    if (outLast32 !== 1'b0)  begin bad++; $display("FAIL rst_last32 got=%0b want=0", outLast32); end
    if (busy32 !== 1'b0)     begin bad++; $display("FAIL rst_busy32 got=%0b want=0", busy32); end
    if (inReady32 !== 1'b0)  begin bad++; $display("FAIL rst_inready32 got=%0b want=0", inReady32); end
    if (outValid64 !== 1'b0) begin bad++; $display("FAIL rst_valid64 got=%0b want=0", outValid64); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    total += 2;
    if (inReady32 !== 1'b1) begin bad++; $display("FAIL post_rst_inready32 got=%0b want=1", inReady32); end
    if (inReady64 !== 1'b1) begin bad++; $display("FAIL post_rst_inready64 got=%0b want=1", inReady64); end
  endtask

  // SHA-256 "abc" at full rate, known words and ROUNDS+1 cycle latency.
  task automatic test_abc256();
    int fi, lo;
    clearQueues(); setAbc(1'b0); addBlock(1'b0);
    runStream(1'b0, 100, 0, 0, 500, fi, lo);
    total++;
    if (rxData.size() != 64) begin
      bad++; $display("FAIL abc_count got=%0d want=64", rxData.size());
    end else begin
      total += 4;
      if (rxData[16] !== 64'h61626380) begin bad++; $display("FAIL abc_w16 got=%h want=61626380", rxData[16]); end
      if (rxData[17] !== 64'h000F0000) begin bad++; $display("FAIL abc_w17 got=%h want=000f0000", rxData[17]); end
      if (rxData[63] !== 64'h12B1EDEB) begin bad++; $display("FAIL abc_w63 got=%h want=12b1edeb", rxData[63]); end
      if (lo - fi != 64) begin bad++; $display("FAIL abc_latency got=%0d want=64", lo - fi); end
    end
    @(negedge clk); #1;
    total += 2;
    if (busy32 !== 1'b0) begin bad++; $display("FAIL abc_busy_end got=%0b want=0", busy32); end
    if (outValid32 !== 1'b0) begin bad++; $display("FAIL abc_valid_end got=%0b want=0", outValid32); end
  endtask

  // Random out_ready and input gaps on the "abc" block.
  task automatic test_backpressure();
    int fi, lo;
    clearQueues(); setAbc(1'b0); addBlock(1'b0);
    runStream(1'b0, 50, 30, 0, 3000, fi, lo);
    total++;
    if (rxData.size() != 64) begin bad++; $display("FAIL bp_count got=%0d want=64", rxData.size()); end
  endtask

  // 64-bit instance: SHA-512 "abc", then a random block under backpressure.
  task automatic test_sha512();
    int fi, lo;
    clearQueues(); setAbc(1'b1); addBlock(1'b1);
    runStream(1'b1, 100, 0, 0, 500, fi, lo);
    total++;
    if (rxData.size() != 80) begin
      bad++; $display("FAIL sha512_count got=%0d want=80", rxData.size());
    end else begin
      total++;
      if (rxData[16] !== 64'h6162638000000000) begin
        bad++; $display("FAIL sha512_w16 got=%h want=6162638000000000", rxData[16]);
      end
    end
    clearQueues(); setRandom(1'b1); addBlock(1'b1);
    runStream(1'b1, 60, 20, 0, 3000, fi, lo);
  endtask

  // Two blocks with in_valid held high throughout.
  task automatic test_back_to_back();
    int fi, lo;
    clearQueues();
    setRandom(1'b0); addBlock(1'b0);
    setRandom(1'b0); addBlock(1'b0);
    runStream(1'b0, 100, 0, 0, 1000, fi, lo);
    total++;
    if (rxData.size() != 128) begin bad++; $display("FAIL b2b_count got=%0d want=128", rxData.size()); end
  endtask

  // Several random blocks with mixed stalls and gaps.
  task automatic test_random_blocks();
    int fi, lo;
    clearQueues();
    for (int b = 0; b < 3; b++) begin
      setRandom(1'b0); addBlock(1'b0);
    end
    runStream(1'b0, 70, 25, 0, 4000, fi, lo);
  endtask

  // rst_n mid-block clears outputs at once; a fresh block is then correct.
  task automatic test_reset_midblock();
    int fi, lo;
    clearQueues(); setAbc(1'b0); addBlock(1'b0);
    runStream(1'b0, 100, 0, 30, 500, fi, lo);
    @(negedge clk); #1;
    total += 2;
    if (outValid32 !== 1'b1) begin bad++; $display("FAIL mid_valid got=%0b want=1", outValid32); end
    if (outRound32 !== 7'd30) begin bad++; $display("FAIL mid_round got=%0d want=30", outRound32); end
    rst_n = 1'b0;
    #1;
    total += 5;
    if (outValid32 !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", outValid32); end
    if (outData32 !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h want=0", outData32); end
    if (outRound32 !== 7'd0) begin bad++; $display("FAIL midrst_round got=%0d want=0", outRound32); end
    if (busy32 !== 1'b0)     begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy32); end
    if (inReady32 !== 1'b0)  begin bad++; $display("FAIL midrst_inready got=%0b want=0", inReady32); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    clearQueues(); setAbc(1'b0); addBlock(1'b0);
    runStream(1'b0, 100, 0, 0, 500, fi, lo);
    total++;
    if (rxData.size() != 64) begin
      bad++; $display("FAIL midrst_count got=%0d want=64", rxData.size());
    end else begin
      total++;
      if (rxData[63] !== 64'h12B1EDEB) begin bad++; $display("FAIL midrst_w63 got=%h want=12b1edeb", rxData[63]); end
    end
  endtask

`ifdef SHA2_MSCHED_ABORT_EN
  // abort_in mid-block drops the pending beat and restarts at round 0.
  task automatic test_abort();
    int fi, lo;
    clearQueues(); setRandom(1'b0); addBlock(1'b0);
    runStream(1'b0, 100, 0, 20, 500, fi, lo);
    @(negedge clk);
    abortIn = 1'b1;
    #1;
    total += 2;
    if (outValid32 !== 1'b1) begin bad++; $display("FAIL abort_pre_valid got=%0b want=1", outValid32); end
    if (outRound32 !== 7'd20) begin bad++; $display("FAIL abort_pre_round got=%0d want=20", outRound32); end
    @(negedge clk);
    abortIn = 1'b0;
    #1;
    total += 2;
    if (outValid32 !== 1'b0) begin bad++; $display("FAIL abort_valid got=%0b want=0", outValid32); end
    if (busy32 !== 1'b0)     begin bad++; $display("FAIL abort_busy got=%0b want=0", busy32); end
    clearQueues(); setRandom(1'b0); addBlock(1'b0);
    runStream(1'b0, 80, 10, 0, 2000, fi, lo);
  endtask
`endif

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_abc256();
    test_backpressure();
    test_sha512();
    test_back_to_back();
    test_random_blocks();
    test_reset_midblock();
`ifdef SHA2_MSCHED_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
